interboard_tx: RTL
==================

Name: interboard_tx

Overview:
Transmit side of the board-to-board link. It sits directly downstream of the slave game controller and consumes that controller's message request: ctrl_en, ctrl_msg_type, ctrl_number and transmit. It sends the 8-bit message to the peer board over a 4-phase request/acknowledge handshake. It returns a one-cycle inter_ready pulse when the peer has fully acknowledged, which the game FSM uses to leave its SEND_* states.

Parameters:
MSG_W, 8, message width on the wire: {msg_type[2:0], number[4:0]}
SYNC_STAGES, 2, flip-flop depth of the rx_ack synchronizer; minimum 2
TIMEOUT_CYCLES, 1000000, ack wait limit in clk cycles; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
interboard_rst  in  1  synchronous clear, active-high; same effect as rst
ctrl_en  in  1  one-cycle request to send a message
ctrl_msg_type  in  3  message type (STATE_TURN / SEL_NUM / STATE_WIN codes)
ctrl_number  in  5  number payload, binary 0..25
transmit  in  1  high while the game FSM is in a sending state
inter_ready  out  1  one-cycle pulse: message delivered
tx_request  out  1  request line to the peer board
tx_data  out  MSG_W  message bus to the peer board
rx_ack  in  1  acknowledge from the peer board, asynchronous
busy  out  1  high from capture until the inter_ready pulse (or abort)
overrun  out  1  sticky: ctrl_en arrived while busy
tx_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst low, asynchronous; or interboard_rst high at a clk edge): state=IDLE; tx_request=0, tx_data=0, inter_ready=0, busy=0, overrun=0, tx_timeout=0; synchronizer flops=0.
- rx_ack passes through SYNC_STAGES flops before use (ack_s). All outputs are registered.
- States: IDLE, REQ, WAIT_ACK_LOW, DONE.
- IDLE:
  - ctrl_en=1 and transmit=1: latch tx_data={ctrl_msg_type,ctrl_number}; set tx_request=1 and busy=1 on the same edge; go to REQ.
  - ctrl_en=1 with transmit=0: ignored, no flag.
- Latency: ctrl_en sampled at edge N gives tx_data and tx_request valid after edge N.
- REQ: hold tx_request=1 and tx_data stable. When ack_s=1: tx_request<=0, go to WAIT_ACK_LOW.
- WAIT_ACK_LOW: tx_data still held. When ack_s=0: go to DONE.
- DONE:
  - transmit=1: inter_ready=1 for exactly one cycle, busy<=0, go to IDLE.
  - transmit=0: stay in DONE; the pulse is deferred until transmit returns high.
- Minimum round trip, peer acking instantly: capture → SYNC_STAGES+1 cycles → request drop → SYNC_STAGES+1 cycles → DONE → pulse. This is 2*SYNC_STAGES+3 cycles after capture.
- ctrl_en while busy=1 (any state except IDLE): request ignored, overrun<=1. The in-flight message is unaffected. overrun clears only on reset.
- ctrl_en on the same edge that DONE emits inter_ready: treated as busy, so overrun is set. The game controller never does this.
- rx_ack=1 while in IDLE (stale ack): ignored. The next capture waits in REQ for a fresh ack_s=1; no ack-low precondition is checked.
- Reset mid-handshake: tx_request drops immediately, and no inter_ready pulse is issued for the aborted message.

Optional Feature:
Macro INTERBOARD_TX_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and WAIT_ACK_LOW and clears on every state change.
  - On reaching TIMEOUT_CYCLES-1: tx_request<=0, busy<=0, tx_timeout pulses for one cycle, go to IDLE. No inter_ready is issued.
- Not defined: no counter; the FSM waits indefinitely; tx_timeout tied to 0.

Decomposition:
- Message-type codes come from the existing message_macro.v; no new copies.
- New header interboard_tx_macro.v holds the state encodings (TX_IDLE, TX_REQ, TX_WAIT_ACK_LOW, TX_DONE) and the {type,number} field positions.
- One sub-module: ack_synchronizer, a parameterized SYNC_STAGES flop chain with asynchronous active-low reset. It is reused later by the receive side.

Test Plan:
- Basic send: transmit=1, ctrl_en with type=SEL_NUM, number=17. Peer acks 1 cycle after seeing tx_request and releases 1 cycle after tx_request drops → tx_data=={SEL_NUM,5'd17} throughout; tx_request high, then low; single inter_ready pulse at cycle 2*SYNC_STAGES+3 plus peer delays; busy low afterwards.
- Deferred completion: drop transmit before ack_s returns low → FSM holds in DONE with inter_ready=0. Raise transmit 5 cycles later → inter_ready pulses on the next edge.
- Overrun: second ctrl_en (type=STATE_WIN, number=3) 2 cycles after the first → tx_data keeps the first message; overrun=1 and stays 1; only one inter_ready.
- Reset mid-handshake: assert rst low asynchronously while in REQ → tx_request=0 immediately. After release, no inter_ready appears, and a fresh send completes normally.
- interboard_rst in WAIT_ACK_LOW → IDLE on the next edge; overrun cleared; stale rx_ack=1 does not start a transfer.
- With INTERBOARD_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16: never ack → tx_timeout pulses at capture+16 cycles, tx_request=0, busy=0, no inter_ready.

Source files
------------

// File: rtl/interboard_tx_pkg.sv
// Shared types for the board-to-board transmit path: FSM state encodings and
// the {type,number} message layout.
package interboard_tx_pkg;

  localparam int TYPE_W   = 3;
  localparam int NUM_W    = 5;
  localparam int MSG_BITS = TYPE_W + NUM_W;

  typedef enum logic [1:0] {
    TX_IDLE         = 2'd0,
    TX_REQ          = 2'd1,
    TX_WAIT_ACK_LOW = 2'd2,
    TX_DONE         = 2'd3
  } tx_state_e;

  // Field order on the wire: type in the upper bits, number in the lower bits.
  typedef struct packed {
    logic [TYPE_W-1:0] msg_type;
    logic [NUM_W-1:0]  number;
  } tx_msg_t;

  function automatic logic [MSG_BITS-1:0] pack_msg(input logic [TYPE_W-1:0] t,
                                                   input logic [NUM_W-1:0]  n);
    tx_msg_t m;
    m.msg_type = t;
    m.number   = n;
    return m;
  endfunction

endpackage

// File: rtl/interboard_tx_if.sv
// Controller request, peer handshake and status signals of the transmit block.
// master = the transmitter, slave = its surroundings (controller + peer).
interface interboard_tx_if
  import interboard_tx_pkg::*;
#(
  parameter int MSG_W = 8
);
  logic              ctrl_en;
  logic [TYPE_W-1:0] ctrl_msg_type;
  logic [NUM_W-1:0]  ctrl_number;
  logic              transmit;
  logic              inter_ready;
  logic              tx_request;
  logic [MSG_W-1:0]  tx_data;
  logic              rx_ack;
  logic              busy;
  logic              overrun;
  logic              tx_timeout;

  modport master (
    input  ctrl_en, ctrl_msg_type, ctrl_number, transmit, rx_ack,
    output inter_ready, tx_request, tx_data, busy, overrun, tx_timeout
  );

  modport slave (
    output ctrl_en, ctrl_msg_type, ctrl_number, transmit, rx_ack,
    input  inter_ready, tx_request, tx_data, busy, overrun, tx_timeout
  );
endinterface

// File: rtl/ack_synchronizer.sv
// STAGES-deep flop chain bringing an asynchronous handshake line into clk.
// clr is a synchronous clear; shared by the transmit and receive sides.
module ack_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     sync_q <= '0;
    else if (clr) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/interboard_tx.sv
// Board-to-board transmitter: 4-phase req/ack send of one {type,number} message.
// Optional ack timeout abort: define INTERBOARD_TX_TIMEOUT_EN.
module interboard_tx
  import interboard_tx_pkg::*;
#(
  parameter int MSG_W          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interboard_rst,
  interboard_tx_if.master io
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("interboard_tx: SYNC_STAGES and TIMEOUT_CYCLES must be at least 2");
  end

  logic ack_s;

  ack_synchronizer #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .clr (interboard_rst),
    .d   (io.rx_ack),
    .q   (ack_s)
  );

  tx_state_e        state;
  logic             req_q;
  logic             ready_q;
  logic             busy_q;
  logic             ovr_q;
  logic [MSG_W-1:0] data_q;

`ifdef INTERBOARD_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             to_q;
  logic             active;
  logic             leave;
  logic             expired;

  assign active  = (state == TX_REQ) || (state == TX_WAIT_ACK_LOW);
  assign leave   = ((state == TX_REQ) && ack_s) || ((state == TX_WAIT_ACK_LOW) && !ack_s);
  assign expired = active && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change so each handshake phase gets a full window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else if (interboard_rst) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= expired;
      cnt  <= (active && !leave && !expired) ? cnt + 1'b1 : '0;
    end
  end

  assign io.tx_timeout = to_q;
`else
  assign io.tx_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= TX_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (interboard_rst) begin
      state   <= TX_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      // Includes the DONE edge that emits inter_ready: still busy there.
      if (io.ctrl_en && state != TX_IDLE) ovr_q <= 1'b1;

      unique case (state)
        TX_IDLE: begin
          if (io.ctrl_en && io.transmit) begin
            data_q <= MSG_W'(pack_msg(io.ctrl_msg_type, io.ctrl_number));
            req_q  <= 1'b1;
            busy_q <= 1'b1;
            state  <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (ack_s) begin
            req_q <= 1'b0;
            state <= TX_WAIT_ACK_LOW;
          end
        end
        TX_WAIT_ACK_LOW: begin
          if (!ack_s) state <= TX_DONE;
        end
        TX_DONE: begin
          // Completion is held back until the game FSM is back in a sending state.
          if (io.transmit) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase

`ifdef INTERBOARD_TX_TIMEOUT_EN
      if (expired) begin
        req_q  <= 1'b0;
        busy_q <= 1'b0;
        state  <= TX_IDLE;
      end
`endif
    end
  end

  assign io.tx_request  = req_q;
  assign io.tx_data     = data_q;
  assign io.inter_ready = ready_q;
  assign io.busy        = busy_q;
  assign io.overrun     = ovr_q;

endmodule
